// File: rtl/scaled_bank_reader.sv
// scaled_bank_reader: tagged 4-entry sample bank with a burst reader that undoes producer scaling
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   wr_en_i        write strobe; stores wr_data_i/wr_mode_i at wr_addr_i, marks entry valid
//   wr_addr_i      write entry index
//   wr_data_i      scaled word from producer
//   wr_mode_i      scaling tag: 00 none, 01 div2, 10 shr2, 11 zeroed
//   rd_start_i     single-cycle burst start pulse (honoured only when idle)
//   rd_base_i      first entry of the burst
//   rd_len_i       words in the burst, 0 = no-op that only pulses done
//   out_valid_o    out_data_o/out_zero_o/out_err_o valid
//   out_ready_i    consumer accept
//   out_data_o     restored word
//   out_zero_o     entry was tagged zeroed
//   out_err_o      entry never written since reset
//   busy_o         burst in progress (FETCH or PRESENT)
//   done_o         one-cycle pulse after the burst completes
//   words_out_o    total words delivered since reset, wraps
module scaled_bank_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [1:0]        wr_mode_i,
    input  logic              rd_start_i,
    input  logic [AW-1:0]     rd_base_i,
    input  logic [CNT_W-1:0]  rd_len_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_zero_o,
    output logic              out_err_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  words_out_o
);
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_e;
    state_e              state_q;
    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [1:0]          mem_mode_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [AW-1:0]       ptr_q;
    logic [CNT_W-1:0]    rem_q;
    logic [DATA_W-1:0]   data_d;
    logic                zero_d;
    logic                err_d;

    // Bank contents carry no reset; the valid bits decide whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_data_q[wr_addr_i] <= wr_data_i;
            mem_mode_q[wr_addr_i] <= wr_mode_i;
        end
    end

    // Restored view of the entry at ptr; an unwritten entry reads as plain zero.
    always_comb begin
        err_d  = !vld_q[ptr_q];
        zero_d = !err_d && (mem_mode_q[ptr_q] == 2'b11);
        data_d = err_d                      ? '0 :
                 mem_mode_q[ptr_q] == 2'b00 ? mem_data_q[ptr_q] :
                 mem_mode_q[ptr_q] == 2'b01 ? mem_data_q[ptr_q] << 1 :
                 mem_mode_q[ptr_q] == 2'b10 ? mem_data_q[ptr_q] << 2 : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_zero_o  <= 1'b0;
            out_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            words_out_o <= '0;
        end else begin
            if (wr_en_i) vld_q[wr_addr_i] <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (rd_start_i && rd_len_i != '0) begin
                        ptr_q   <= rd_base_i;
                        rem_q   <= rd_len_i;
                        busy_o  <= 1'b1;
                        state_q <= FETCH;
                    end else if (rd_start_i) begin
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                // Reads the bank before any same-cycle write lands, so a colliding write shows up only later.
                FETCH: begin
                    out_data_o  <= data_d;
                    out_zero_o  <= zero_d;
                    out_err_o   <= err_d;
                    out_valid_o <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        words_out_o <= words_out_o + CNT_W'(1);
                        rem_q       <= rem_q - CNT_W'(1);
                        ptr_q       <= ptr_q + AW'(1);
                        if (rem_q == CNT_W'(1)) begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scaled_bank_reader.sv
// tb_scaled_bank_reader: directed self-checking bench for scaled_bank_reader
module tb_scaled_bank_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_mode = '0;
    logic        rd_start = 1'b0;
    logic [1:0]  rd_base = '0;
    logic [7:0]  rd_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_err;
    logic        busy;
    logic        done;
    logic [7:0]  words_out;
    int          passed = 0;
    int          total = 0;

    scaled_bank_reader dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mode_i(wr_mode),
        .rd_start_i(rd_start), .rd_base_i(rd_base), .rd_len_i(rd_len),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_zero_o(out_zero), .out_err_o(out_err),
        .busy_o(busy), .done_o(done), .words_out_o(words_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called on a negedge; the write lands on the following posedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mode = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [1:0] b, input logic [7:0] l);
        rd_start = 1'b1; rd_base = b; rd_len = l;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    task automatic get_word(input string tag, input logic [31:0] d, input logic z, input logic e);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(out_valid), 1);
        check({tag, " data"}, out_data, d);
        check({tag, " zero"}, 32'(z), 32'(out_zero));
        check({tag, " err"}, 32'(out_err), 32'(e));
        @(negedge clk);
    endtask

    task automatic finish_burst(input string tag, input logic [7:0] w);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " words"}, 32'(words_out), 32'(w));
        @(negedge clk);
        check({tag, " done drop"}, 32'(done), 0);
        check({tag, " idle"}, 32'(busy), 0);
    endtask

    initial begin
        #2;
        check("rst valid", 32'(out_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst words", 32'(words_out), 0);
        check("rst data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wr(0, 32'h10, 2'b00);
        wr(1, 32'h10, 2'b01);
        wr(2, 32'h10, 2'b10);
        wr(3, 32'h1234, 2'b11);
        start(0, 4);
        check("s1 fetch valid", 32'(out_valid), 0);
        check("s1 busy", 32'(busy), 1);
        get_word("s1 w0", 32'h10, 0, 0);
        get_word("s1 w1", 32'h20, 0, 0);
        get_word("s1 w2", 32'h40, 0, 0);
        get_word("s1 w3", 32'h0, 1, 0);
        finish_burst("s1", 4);

        start(3, 3);
        get_word("s2 e3", 32'h0, 1, 0);
        get_word("s2 e0", 32'h10, 0, 0);
        get_word("s2 e1", 32'h20, 0, 0);
        finish_burst("s2", 7);

        out_ready = 1'b0;
        start(2, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("s3 hold valid", 32'(out_valid), 1);
            check("s3 hold data", out_data, 32'h40);
            check("s3 hold words", 32'(words_out), 7);
            @(negedge clk);
        end
        out_ready = 1'b1;
        get_word("s3 w", 32'h40, 0, 0);
        finish_burst("s3", 8);

        out_ready = 1'b0;
        start(1, 1);
        @(negedge clk);
        wr(1, 32'hAA, 2'b00);
        check("s5a held", out_data, 32'h20);
        out_ready = 1'b1;
        get_word("s5a w", 32'h20, 0, 0);
        finish_burst("s5a", 9);

        start(0, 5);
        wr(0, 32'hBB, 2'b00);
        get_word("s5b e0 old", 32'h10, 0, 0);
        get_word("s5b e1", 32'hAA, 0, 0);
        get_word("s5b e2", 32'h40, 0, 0);
        get_word("s5b e3", 32'h0, 1, 0);
        get_word("s5b e0 new", 32'hBB, 0, 0);
        finish_burst("s5b", 14);

        start(2, 2);
        start(0, 1);
        get_word("s5c e2", 32'h40, 0, 0);
        get_word("s5c e3", 32'h0, 1, 0);
        finish_burst("s5c", 16);
        @(negedge clk);
        check("s5c no queued", 32'(out_valid | busy), 0);

        start(0, 0);
        check("s6 len0 valid", 32'(out_valid), 0);
        finish_burst("s6 len0", 16);

        wr(2, 32'hC000_0000, 2'b10);
        start(2, 1);
        get_word("s6 ovf", 32'h0, 0, 0);
        finish_burst("s6 ovf", 17);

        out_ready = 1'b0;
        start(0, 1);
        @(negedge clk);
        check("s6 pre-rst valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6 rst valid", 32'(out_valid), 0);
        check("s6 rst data", out_data, 0);
        check("s6 rst busy", 32'(busy), 0);
        check("s6 rst words", 32'(words_out), 0);
        @(negedge clk);
        check("s6 rst no done", 32'(done), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("s6 post no done", 32'(done), 0);
        start(2, 1);
        get_word("s6 unwritten", 32'h0, 0, 1);
        finish_burst("s6 after rst", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/scaled_bank_reader.md
Name: scaled_bank_reader

Overview:
- Read-side counterpart of the team's 4-entry scaled sample bank.
- The producer writes 32-bit words tagged with the scaling it applied: none, /2, >>2, or zeroed.
- This block stores those tagged words and streams a requested burst back out over a valid/ready handshake, undoing the scaling on the way out.
- It sits between the sample-bank writer and downstream display/checker logic.

Parameters:
DATA_W, 32, data word width
DEPTH, 4, number of bank entries (power of two)
CNT_W, 8, width of the burst-length and delivered-word counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write strobe into bank
wr_addr  input  log2(DEPTH)  write entry index
wr_data  input  DATA_W  scaled word from producer
wr_mode  input  2  scaling tag: 00 none, 01 div2, 10 shr2, 11 zeroed
rd_start  input  1  single-cycle pulse; starts a burst (ignored unless IDLE)
rd_base  input  log2(DEPTH)  first entry of burst, sampled with rd_start
rd_len  input  CNT_W  words in burst, sampled with rd_start; 0 = no-op
out_valid  output  1  out_data/out_zero valid
out_ready  input  1  consumer accept
out_data  output  DATA_W  restored word
out_zero  output  1  entry was tagged zeroed
out_err  output  1  entry never written since reset
busy  output  1  burst in progress
done  output  1  one-cycle pulse after last word accepted
words_out  output  CNT_W  total words delivered since reset, wraps

Behaviour:
- Reset (async, reset=0): all outputs 0. Entry-valid bits 0, FSM=IDLE, words_out=0. Bank data need not be reset.
- Write port: wr_en=1 stores wr_data and wr_mode at wr_addr and sets that entry's valid bit. A write is always accepted, in any FSM state.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - rd_start=1 with rd_len!=0 latches ptr=rd_base and remaining=rd_len, then goes to FETCH.
  - rd_start=1 with rd_len=0 goes directly to DONE.
- FETCH (1 cycle): registers the entry at ptr into the output register, then goes to PRESENT.
  - Restore rule by tag:
    - 00: out_data = data
    - 01: out_data = data<<1, low bit 0
    - 10: out_data = data<<2, low bits 0
    - 11: out_data = 0, out_zero = 1
  - Shifts truncate to DATA_W; bits shifted out are dropped.
  - out_err = !valid[ptr]. When out_err=1, out_data = 0 and out_zero = 0.
- PRESENT:
  - out_valid=1. out_data, out_zero and out_err are held stable until out_valid && out_ready.
  - On accept: words_out++, remaining--, ptr = (ptr+1) mod DEPTH (wraps 3->0).
  - After accept, go to FETCH if remaining != 0, else to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in FETCH and PRESENT only.
- Latency: rd_start to first out_valid = 2 cycles. Back-to-back words with out_ready held high arrive every 2 cycles (FETCH bubble).
- Write vs read collision:
  - A write to ptr in the same cycle as FETCH: FETCH reads the old contents; the new value is visible to later fetches.
  - A write during PRESENT never alters the presented word.
- Bursts longer than DEPTH wrap and re-read entries.
- rd_start while busy or in DONE is ignored, with no queuing.
- Reset asserted mid-burst aborts immediately: out_valid=0, and done is not pulsed.

Test Plan:
1. Write entries 0..3:
   - entry 0 = 0x10, mode 00
   - entry 1 = 0x10, mode 01
   - entry 2 = 0x10, mode 10
   - entry 3 = 0x1234, mode 11
   - Then burst base 0, len 4, ready high.
   - Required: out_data 0x10, 0x20, 0x40, 0x0, with out_zero only on the 4th word; done pulses once; words_out=4.
2. Wrap: base 3, len 3.
   - Required: entries delivered in order 3, 0, 1; done after the 3rd accept.
3. Backpressure: hold out_ready=0 for 5 cycles in PRESENT.
   - Required: out_valid and out_data stay constant; words_out unchanged until ready rises.
4. Unwritten entry after reset: burst base 2, len 1 with no prior writes.
   - Required: out_err=1, out_data=0.
5. Collisions and ignored starts:
   - Write 0xAA to the entry being presented: output unchanged.
   - Write 0xBB to the entry in the same cycle as its FETCH: the old value is delivered, and 0xBB is delivered on the next wrap.
   - rd_start while busy: ignored.
6. Edge controls:
   - rd_len=0: done one cycle later, no out_valid.
   - Assert reset mid-PRESENT: all outputs 0 in the same cycle, no done pulse; a new burst after reset release behaves as in scenario 4.
   - Shift overflow: data 0xC000_0000 with mode 10 returns 0x0.
